// File: rtl/cla_pipe_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor. Each of STAGES
// segments sums SEG bits per cycle; the segment carry and operand skew travel with the beat.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLOCK;

  if (STAGES < 1 || (WIDTH % (STAGES * BLOCK)) != 0) begin : g_param_err
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*BLOCK and STAGES >= 1");
  end

  typedef struct packed {
    logic [SEG-1:0] sum;
    logic           cout;
    logic           cmsb;   // carry into the segment MSB
  } seg_res_t;

  // Pipeline word: upper operand bits not yet summed ride along with the
  // low result bits already produced; carry is the segment carry-out.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;
  } stage_t;

  // Two-level CLA over one segment. Every carry is a flat sum of products of
  // group (or bit) generate/propagate terms, so nothing ripples between groups.
  function automatic seg_res_t seg_add(input logic [SEG-1:0] a,
                                       input logic [SEG-1:0] b,
                                       input logic           cin);
    logic [SEG-1:0]  g, p, c;
    logic [NGRP-1:0] gg, gp;
    logic [NGRP:0]   gc;
    logic            t;
    seg_res_t        r;
    // NOTE: functions and always_comb use blocking '=' so each statement sees
    // the previous one's value; only clocked state uses '<='.
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NGRP; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        gg[j] = g[j*BLOCK+i] | (p[j*BLOCK+i] & gg[j]);
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    for (int j = 0; j <= NGRP; j++) begin
      gc[j] = cin;
      for (int m = 0; m < j; m++) gc[j] = gc[j] & gp[m];
      for (int m = 0; m < j; m++) begin
        t = gg[m];
        for (int n = m + 1; n < j; n++) t = t & gp[n];
        gc[j] = gc[j] | t;
      end
    end
    for (int j = 0; j < NGRP; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        c[j*BLOCK+i] = gc[j];
        for (int m = 0; m < i; m++) c[j*BLOCK+i] = c[j*BLOCK+i] & p[j*BLOCK+m];
        for (int m = 0; m < i; m++) begin
          t = g[j*BLOCK+m];
          for (int n = m + 1; n < i; n++) t = t & p[j*BLOCK+n];
          c[j*BLOCK+i] = c[j*BLOCK+i] | t;
        end
      end
    end
    r.sum  = p ^ c;
    r.cout = gc[NGRP];
    r.cmsb = c[SEG-1];
    return r;
  endfunction

  stage_t   stage_q [STAGES];
  stage_t   stage_d [STAGES];
  stage_t   prev    [STAGES];
  seg_res_t res     [STAGES];
  logic     adv;

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_sum   = stage_q[STAGES-1].sum;
  assign out_cout  = stage_q[STAGES-1].carry;
  assign out_ovf   = stage_q[STAGES-1].ovf;
  assign out_zero  = stage_q[STAGES-1].zero;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rst_n && adv;

  always_comb begin
    prev[0]       = '0;
    prev[0].valid = in_valid;
    prev[0].a     = in_a;
    prev[0].b     = in_sub ? ~in_b : in_b;
    prev[0].carry = in_sub | in_cin;
    for (int k = 1; k < STAGES; k++) prev[k] = stage_q[k-1];

    for (int k = 0; k < STAGES; k++) begin
      res[k]                     = seg_add(prev[k].a[k*SEG +: SEG],
                                           prev[k].b[k*SEG +: SEG],
                                           prev[k].carry);
      stage_d[k]                 = prev[k];
      stage_d[k].sum[k*SEG +: SEG] = res[k].sum;
      stage_d[k].carry           = res[k].cout;
      // Only the last stage's flags reach the outputs; earlier ones are don't-care.
      stage_d[k].ovf             = res[k].cmsb ^ res[k].cout;
      stage_d[k].zero            = ~|stage_d[k].sum;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the whole stage array is reset, not just the valid bits, because
    // the result and flag outputs are read straight from the last stage.
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

endmodule
